// File: rtl/mesi_state_engine.sv
// rtl/mesi_state_engine.sv - registered MESI next-state engine with saturating error counter
module mesi_state_engine #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [1:0]           present_state,
    input  logic [3:0]           command,
    input  logic [1:0]           snoop_result,
    output logic                 result_valid,
    output logic [3:0]           result,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] error_count
);

    // Line states
    localparam logic [1:0] ST_M = 2'b00;
    localparam logic [1:0] ST_E = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;
    localparam logic [1:0] ST_I = 2'b11;

    // Commands
    localparam logic [3:0] CMD_L1_RD    = 4'd0;
    localparam logic [3:0] CMD_L1_WR    = 4'd1;
    localparam logic [3:0] CMD_L1_IRD   = 4'd2;
    localparam logic [3:0] CMD_SNP_INV  = 4'd3;
    localparam logic [3:0] CMD_SNP_RD   = 4'd4;
    localparam logic [3:0] CMD_SNP_WR   = 4'd5;
    localparam logic [3:0] CMD_SNP_RFO  = 4'd6;
    localparam logic [3:0] CMD_CLEAR    = 4'd8;
    localparam logic [3:0] CMD_PRINT    = 4'd9;

    // Side codes: bus ops for L1 commands, snoop responses for snoop commands
    localparam logic [1:0] BUS_INV   = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_NONE  = 2'b10;
    localparam logic [1:0] BUS_RWIM  = 2'b11;
    localparam logic [1:0] SNP_NOHIT = 2'b00;
    localparam logic [1:0] SNP_HIT   = 2'b01;
    localparam logic [1:0] SNP_HITM  = 2'b10;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] nxt_state;
    logic [1:0] nxt_side;
    logic       nxt_err;
    logic       other_has_copy;

    // 2'b11 from the snoop bus is treated as NoHIT
    assign other_has_copy = (snoop_result == SNP_HIT) || (snoop_result == SNP_HITM);

    // Next-state / side-code decode for one lookup
    always_comb begin
        nxt_state = present_state;
        nxt_side  = SNP_NOHIT;
        nxt_err   = 1'b0;
        case (command)
            CMD_L1_RD, CMD_L1_IRD: begin
                if (present_state == ST_I) begin
                    nxt_state = other_has_copy ? ST_S : ST_E;
                    nxt_side  = BUS_READ;
                end else begin
                    nxt_side  = BUS_NONE;
                end
            end
            CMD_L1_WR: begin
                nxt_state = ST_M;
                case (present_state)
                    ST_M, ST_E: nxt_side = BUS_NONE;
                    ST_S:       nxt_side = BUS_INV;
                    default:    nxt_side = BUS_RWIM;
                endcase
            end
            CMD_SNP_RD, CMD_SNP_RFO: begin
                case (present_state)
                    ST_M:    nxt_side = SNP_HITM;
                    ST_E,
                    ST_S:    nxt_side = SNP_HIT;
                    default: nxt_side = SNP_NOHIT;
                endcase
                if (command == CMD_SNP_RD && present_state != ST_I)
                    nxt_state = ST_S;
                else
                    nxt_state = ST_I;
            end
            CMD_SNP_INV: begin
                case (present_state)
                    ST_S: begin
                        nxt_state = ST_I;
                        nxt_side  = SNP_HIT;
                    end
                    ST_I: begin
                        nxt_state = ST_I;
                        nxt_side  = SNP_NOHIT;
                    end
                    default: nxt_err = 1'b1;
                endcase
            end
            CMD_SNP_WR: begin
                if (present_state == ST_I) begin
                    nxt_state = ST_I;
                    nxt_side  = SNP_NOHIT;
                end else begin
                    nxt_err = 1'b1;
                end
            end
            CMD_CLEAR: begin
                nxt_state = ST_I;
                nxt_side  = BUS_NONE;
            end
            CMD_PRINT: begin
                nxt_side  = BUS_NONE;
            end
            default: nxt_err = 1'b1;
        endcase
        // Illegal lookups leave the line untouched and report side 00
        if (nxt_err) begin
            nxt_state = present_state;
            nxt_side  = 2'b00;
        end
    end

    // Output register; result/error hold between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            result       <= 4'b0000;
            error        <= 1'b0;
            error_count  <= '0;
        end else begin
            result_valid <= req_valid;
            if (req_valid) begin
                result <= {nxt_state, nxt_side};
                error  <= nxt_err;
                if (nxt_err && (error_count != CNT_MAX))
                    error_count <= error_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mesi_state_engine.sv
// tb/tb_mesi_state_engine.sv - scoreboard bench for mesi_state_engine
module tb_mesi_state_engine;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [1:0]    present_state = 2'b00;
    logic [3:0]    command = 4'd0;
    logic [1:0]    snoop_result = 2'b00;
    logic          result_valid;
    logic [3:0]    result;
    logic          error;
    logic [CW-1:0] error_count;

    mesi_state_engine #(.ERR_CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .present_state (present_state),
        .command       (command),
        .snoop_result  (snoop_result),
        .result_valid  (result_valid),
        .result        (result),
        .error         (error),
        .error_count   (error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    res;
        logic          err;
        logic [CW-1:0] cnt;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            started = 1'b0;
    logic [3:0]    last_res = 4'b0;
    logic          last_err = 1'b0;
    logic [CW-1:0] model_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {next_state, side, err}; M=0 E=1 S=2 I=3
    function automatic logic [4:0] model(input logic [1:0] st, input logic [3:0] cmd, input logic [1:0] snp);
        bit         present = (st != 2'd3);
        bit         dirty   = (st == 2'd0);
        logic [1:0] ns;
        logic [1:0] sd;
        bit         bad = 0;
        ns = st;
        sd = 2'b00;
        if (cmd == 0 || cmd == 2) begin
            if (present) sd = 2'b10;
            else begin
                ns = (snp == 2'b01 || snp == 2'b10) ? 2'd2 : 2'd1;
                sd = 2'b01;
            end
        end else if (cmd == 1) begin
            ns = 2'd0;
            sd = (st == 2'd0 || st == 2'd1) ? 2'b10 : (st == 2'd2) ? 2'b00 : 2'b11;
        end else if (cmd == 4 || cmd == 6) begin
            sd = !present ? 2'b00 : dirty ? 2'b10 : 2'b01;
            ns = (cmd == 4 && present) ? 2'd2 : 2'd3;
        end else if (cmd == 3) begin
            if (st == 2'd0 || st == 2'd1) bad = 1;
            else begin
                ns = 2'd3;
                sd = present ? 2'b01 : 2'b00;
            end
        end else if (cmd == 5) begin
            if (present) bad = 1;
            else ns = 2'd3;
        end else if (cmd == 8) begin
            ns = 2'd3;
            sd = 2'b10;
        end else if (cmd == 9) begin
            sd = 2'b10;
        end else begin
            bad = 1;
        end
        if (bad) begin
            ns = st;
            sd = 2'b00;
        end
        return {ns, sd, bad};
    endfunction

    task automatic issue(input logic [1:0] st, input logic [3:0] cmd, input logic [1:0] snp);
        logic [4:0] m;
        exp_t       e;
        @(posedge clk);
        #1;
        req_valid     = 1'b1;
        present_state = st;
        command       = cmd;
        snoop_result  = snp;
        m = model(st, cmd, snp);
        if (m[0] && model_cnt != {CW{1'b1}}) model_cnt = model_cnt + 1'b1;
        e.res = m[4:1];
        e.err = m[0];
        e.cnt = model_cnt;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    // Monitor: pops expectations on result_valid, checks hold otherwise
    always @(negedge clk) begin
        if (started) begin
            if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(result_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.cyc));
                    chk("result", 32'(result), 32'(e.res));
                    chk("error", 32'(error), 32'(e.err));
                    chk("error_count", 32'(error_count), 32'(e.cnt));
                    last_res = e.res;
                    last_err = e.err;
                end
            end else begin
                chk("hold_result", 32'(result), 32'(last_res));
                chk("hold_error", 32'(error), 32'(last_err));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_count", 32'(error_count), 32'd0);
        started = 1'b1;

        // Snoops from M, then illegal snoops
        issue(2'd0, 4'd4, 2'b00);
        issue(2'd0, 4'd6, 2'b00);
        issue(2'd0, 4'd3, 2'b00);
        issue(2'd1, 4'd5, 2'b00);
        issue(2'd2, 4'd5, 2'b00);
        // Invalid-state misses
        issue(2'd3, 4'd0, 2'b01);
        issue(2'd3, 4'd2, 2'b10);
        issue(2'd3, 4'd2, 2'b00);
        issue(2'd3, 4'd2, 2'b11);
        issue(2'd3, 4'd1, 2'b01);
        // Shared/Exclusive
        issue(2'd2, 4'd1, 2'b00);
        issue(2'd2, 4'd3, 2'b00);
        issue(2'd2, 4'd6, 2'b00);
        issue(2'd1, 4'd1, 2'b00);
        issue(2'd1, 4'd4, 2'b00);
        issue(2'd1, 4'd8, 2'b01);
        issue(2'd0, 4'd9, 2'b10);
        idle(2);
        // Three-pulse burst then idle hold
        issue(2'd0, 4'd4, 2'b00);
        issue(2'd3, 4'd15, 2'b00);
        issue(2'd3, 4'd0, 2'b00);
        idle(3);

        // Reset together with an illegal request
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1;
        present_state = 2'd1;
        command = 4'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        model_cnt = '0;
        last_res = 4'b0;
        last_err = 1'b0;
        chk("rst_req_valid", 32'(result_valid), 32'd0);
        chk("rst_req_result", 32'(result), 32'd0);
        chk("rst_req_count", 32'(error_count), 32'd0);

        // Saturation
        for (int i = 0; i < 20; i++) issue(2'(i % 4), 4'd7, 2'b00);
        idle(2);
        chk("saturated", 32'(error_count), 32'(model_cnt));
        chk("saturated_max", 32'(error_count), 32'hF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) != 0)
                issue(2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)));
            else
                idle(1);
        end
        idle(3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_state_engine.md
Name: mesi_state_engine

Overview:
Registered MESI coherence next-state engine for the split L2 cache controller. Each cycle it can accept one lookup: the present MESI state of a line, the trace command, and the snoop result returned by other caches. One cycle later it returns:
- the line's next state;
- a 2-bit side code, which is the bus operation to issue for L1 commands or the snoop result this cache drives for snoop commands;
- an error flag for protocol-illegal combinations.

The controller writes the next state back into the tag array and forwards the side code to the bus/snoop model.

Parameters:
ERR_CNT_W, 16, width of the saturating protocol-error counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  lookup request strobe
present_state  input  2  current line state: 00 Modified, 01 Exclusive, 10 Shared, 11 Invalid
command  input  4  0 L1 data read, 1 L1 data write, 2 L1 instr read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RFO, 8 clear cache, 9 print cache
snoop_result  input  2  other caches' response: 00 NoHIT, 01 HIT, 10 HITM (11 treated as NoHIT)
result_valid  output  1  result/error valid, one cycle after req_valid
result  output  4  {next_state[1:0], side_code[1:0]}
error  output  1  illegal state/command combination
error_count  output  ERR_CNT_W  saturating count of errored lookups

Behaviour:
- Reset (rst=1 at a clock edge, which takes priority over req_valid) sets result_valid=0, result=4'b0000, error=0, error_count=0.
- Timing:
  - Fixed latency of 1: inputs are sampled at the edge where req_valid=1, and outputs are valid after that edge.
  - Back-to-back requests are allowed every cycle; there is no backpressure.
  - When req_valid=0, result_valid drops to 0 at the next edge and result/error hold their last values.
  - A request sampled in the same cycle as rst is discarded.
- Side code meaning for L1 commands (0,1,2): 00 bus INVALIDATE, 01 bus READ, 10 no bus op, 11 bus RWIM.
- Side code meaning for snoop commands (3..6): 00 NoHIT, 01 HIT, 10 HITM.
- L1 read (cmd 0 or 2):
  - M, E and S keep their state, side 10.
  - I with snoop_result HIT or HITM goes to S, side 01 (result 1001).
  - I with snoop_result NoHIT goes to E, side 01 (result 0101).
- L1 write (cmd 1):
  - M goes to M, side 10 (0010).
  - E goes to M, side 10 (0010).
  - S goes to M, side 00 (0000).
  - I goes to M, side 11 (0011).
- Snoop read (cmd 4):
  - M goes to S with HITM (1010).
  - E goes to S with HIT (1001).
  - S goes to S with HIT (1001).
  - I stays I with NoHIT (1100).
- Snoop RFO (cmd 6):
  - M goes to I with HITM (1110).
  - E goes to I with HIT (1101).
  - S goes to I with HIT (1101).
  - I stays I with NoHIT (1100).
- Snoop invalidate (cmd 3):
  - S goes to I with HIT (1101).
  - I stays I with NoHIT (1100).
  - M and E are errors.
- Snoop write (cmd 5):
  - I stays I with NoHIT (1100).
  - M, E and S are errors.
- Clear cache (cmd 8): any state goes to I, side 10. Print cache (cmd 9): state unchanged, side 10. Neither is an error.
- Error cases: the illegal snoops listed above plus commands 7 and 10..15. On an error:
  - next_state = present_state and side = 00;
  - error=1 with result_valid=1;
  - error_count increments, saturating at all-ones.
- For every non-error case, error=0.
- snoop_result is ignored for every case except L1 read from Invalid.

Test Plan:
- Snoop read/RFO from M: (M, cmd 4) -> result 1010 with error 0; (M, cmd 6) -> 1110.
- Illegal snoops:
  - (M, cmd 3) -> 0000, error 1; (E, cmd 5) -> 0100, error 1; (S, cmd 5) -> 1000, error 1.
  - error_count reads 3 after these three.
- Invalid-state L1 misses:
  - (I, cmd 0, HIT) -> 1001; (I, cmd 2, HITM) -> 1001; (I, cmd 2, NoHIT) -> 0101.
  - (I, cmd 1, HIT) -> 0011.
- Shared/Exclusive transitions:
  - (S, cmd 1) -> 0000; (S, cmd 3) -> 1101; (S, cmd 6) -> 1101.
  - (E, cmd 1) -> 0010; (E, cmd 4) -> 1001.
- Handshake/latency:
  - req_valid pulsed for 3 consecutive cycles -> result_valid high for exactly the 3 following cycles, each result matching its own request.
  - Idle cycles after that hold result with result_valid=0.
- Reset:
  - Assert rst together with req_valid for an illegal (E, cmd 3) -> next edge gives result_valid=0, result=0000, error_count=0.
  - Drive error_count to saturation -> it holds at all-ones on further errors.
